// File: rtl/noise_alpha_ctrl_if.sv
// Sample-in / coefficient-out bundle for noise_alpha_ctrl.
//
// Handshake: x_valid is a single-cycle strobe qualifying x_in with no
// back-pressure (there is no ready; every strobed sample is consumed).
// alpha_valid pulses exactly one cycle after each accepted sample, and
// alpha, speech_active and noise_floor change only on that same edge.
interface noise_alpha_ctrl_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] x_in;
  logic                    x_valid;
  logic signed [WIDTH-1:0] alpha;
  logic                    alpha_valid;
  logic                    speech_active;
  logic        [WIDTH-1:0] noise_floor;

  // Sample source / coefficient consumer side
  modport master (
    output x_in, x_valid,
    input  alpha, alpha_valid, speech_active, noise_floor
  );

  // Controller side
  modport slave (
    input  x_in, x_valid,
    output alpha, alpha_valid, speech_active, noise_floor
  );
endinterface

// File: rtl/noise_alpha_ctrl.sv
// noise_alpha_ctrl: envelope follower + windowed-minimum noise floor +
// WARMUP/NOISE/SPEECH/HANGOVER detector that selects a smoothing
// coefficient for a downstream filter.
// Optional feature macro ALPHA_RAMP_EN: when defined, alpha slews toward
// its target by at most ALPHA_STEP per valid sample; when undefined alpha
// jumps straight to the target.
module noise_alpha_ctrl #(
  parameter int WIDTH         = 16,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 6,
  parameter int WIN_LEN       = 1024,
  parameter int THR_SHIFT     = 2,
  parameter int HANG_LEN      = 256,
  parameter int ALPHA_MIN     = 1638,
  parameter int ALPHA_MAX     = 32767,
  parameter int ALPHA_STEP    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  noise_alpha_ctrl_if.slave    bus,
  output logic [1:0]           dbg_state,
  output logic [WIDTH-1:0]     dbg_env
);

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_NOISE    = 2'd1,
    ST_SPEECH   = 2'd2,
    ST_HANGOVER = 2'd3
  } state_t;

  localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int HANG_W = (HANG_LEN > 1) ? $clog2(HANG_LEN) : 1;
  localparam int THR_W  = WIDTH + THR_SHIFT;

  localparam logic [WIDTH-1:0]        POS_FULL  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        NEG_FULL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIN_W-1:0]        WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [HANG_W-1:0]       HANG_LAST = HANG_W'(HANG_LEN - 1);
  localparam logic signed [WIDTH-1:0] A_MIN     = WIDTH'(ALPHA_MIN);
  localparam logic signed [WIDTH-1:0] A_MAX     = WIDTH'(ALPHA_MAX);

  // Refuse to elaborate with a parameter set the datapath cannot honour
  if (ALPHA_STEP < 1 || ALPHA_MIN > ALPHA_MAX || WIN_LEN < 1 ||
      (WIN_LEN & (WIN_LEN - 1)) != 0) begin : g_bad_cfg
    $error("noise_alpha_ctrl: illegal parameter set");
  end

  state_t                  state, state_next;
  logic [HANG_W-1:0]       hang_cnt, hang_next;
  logic [WIDTH-1:0]        mag;
  logic [WIDTH-1:0]        env, env_next, env_delta, env_step;
  logic [WIDTH-1:0]        window_min;
  logic [WIN_W-1:0]        win_cnt;
  logic [WIDTH-1:0]        noise_floor_r;
  logic [THR_W-1:0]        thr;
  logic                    loud;
  logic                    win_end;
  logic signed [WIDTH-1:0] alpha_r, alpha_target, alpha_next;
  logic                    alpha_valid_r;
  logic                    speech_r;

  // Saturating magnitude: the most negative code maps to the largest positive
  always_comb begin
    mag = bus.x_in;
    if (bus.x_in[WIDTH-1]) begin
      if (bus.x_in == NEG_FULL) mag = POS_FULL;
      else                      mag = -bus.x_in;
    end
  end

  // Asymmetric envelope step, never smaller than one LSB so env always converges
  always_comb begin
    env_delta = '0;
    env_step  = '0;
    env_next  = env;
    if (mag > env) begin
      env_delta = mag - env;
      env_step  = env_delta >> ATTACK_SHIFT;
      if (env_step == '0) env_step = WIDTH'(1);
      env_next  = env + env_step;
    end else if (mag < env) begin
      env_delta = env - mag;
      env_step  = env_delta >> RELEASE_SHIFT;
      if (env_step == '0) env_step = WIDTH'(1);
      env_next  = env - env_step;
    end
  end

  // Threshold is widened so the shift cannot overflow; uses the floor held in
  // the register, not the value being loaded on a window-end sample
  always_comb begin
    thr     = THR_W'(noise_floor_r) << THR_SHIFT;
    loud    = THR_W'(env_next) > thr;
    win_end = (win_cnt == WIN_LAST);
  end

  // Envelope, running window minimum and noise-floor registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      env           <= '0;
      window_min    <= POS_FULL;
      win_cnt       <= '0;
      noise_floor_r <= '0;
    end else if (bus.x_valid) begin
      env     <= env_next;
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      if (win_end) begin
        noise_floor_r <= (env_next < window_min) ? env_next : window_min;
        window_min    <= POS_FULL;
      end else if (env_next < window_min) begin
        window_min <= env_next;
      end
    end
  end

  // FSM state register and hangover counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_WARMUP;
      hang_cnt <= '0;
    end else begin
      state    <= state_next;
      hang_cnt <= hang_next;
    end
  end

  // FSM next state; moves only on a valid sample
  always_comb begin
    state_next = state;
    hang_next  = hang_cnt;
    if (bus.x_valid) begin
      case (state)
        ST_WARMUP: begin
          if (win_end) state_next = ST_NOISE;
        end
        ST_NOISE: begin
          if (loud) state_next = ST_SPEECH;
        end
        ST_SPEECH: begin
          if (!loud) begin
            state_next = ST_HANGOVER;
            hang_next  = HANG_LAST;
          end
        end
        ST_HANGOVER: begin
          if (loud)                 state_next = ST_SPEECH;
          else if (hang_cnt == '0)  state_next = ST_NOISE;
          else                      hang_next  = hang_cnt - 1'b1;
        end
        default: state_next = ST_WARMUP;
      endcase
    end
  end

`ifdef ALPHA_RAMP_EN
  localparam logic signed [WIDTH-1:0] A_STEP = WIDTH'(ALPHA_STEP);
  localparam logic signed [WIDTH:0]   STEP_W = (WIDTH+1)'(ALPHA_STEP);
  logic signed [WIDTH:0] alpha_diff;
`endif

  // FSM output: target coefficient from the next state, optionally slewed
  always_comb begin
    alpha_target = (state_next == ST_NOISE) ? A_MIN : A_MAX;
`ifdef ALPHA_RAMP_EN
    alpha_diff = (WIDTH+1)'(alpha_target) - (WIDTH+1)'(alpha_r);
    if (alpha_diff > STEP_W)       alpha_next = alpha_r + A_STEP;
    else if (alpha_diff < -STEP_W) alpha_next = alpha_r - A_STEP;
    else                           alpha_next = alpha_target;
`else
    alpha_next = alpha_target;
`endif
  end

  // Output registers: everything downstream sees changes on one edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      alpha_r       <= A_MAX;
      alpha_valid_r <= 1'b0;
      speech_r      <= 1'b0;
    end else begin
      alpha_valid_r <= bus.x_valid;
      if (bus.x_valid) begin
        alpha_r  <= alpha_next;
        speech_r <= (state_next == ST_SPEECH) || (state_next == ST_HANGOVER);
      end
    end
  end

  assign bus.alpha         = alpha_r;
  assign bus.alpha_valid   = alpha_valid_r;
  assign bus.speech_active = speech_r;
  assign bus.noise_floor   = noise_floor_r;
  assign dbg_state         = state;
  assign dbg_env           = env;

endmodule

// File: doc/noise_alpha_ctrl.md
NOISE_ALPHA_CTRL -- requirements
Module: noise_alpha_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample/coefficient width (Q1.15 signed).
REQ-002 SHALL have parameter ATTACK_SHIFT, default 2, envelope attack right-shift.
REQ-003 SHALL have parameter RELEASE_SHIFT, default 6, envelope release right-shift.
REQ-004 SHALL have parameter WIN_LEN, default 1024, noise-floor window length in valid samples (power of 2).
REQ-005 SHALL have parameter THR_SHIFT, default 2, speech threshold = noise_floor << THR_SHIFT.
REQ-006 SHALL have parameter HANG_LEN, default 256, hangover length in valid samples.
REQ-007 SHALL have parameters ALPHA_MIN = 1638, ALPHA_MAX = 32767, ALPHA_STEP = 64 (Q1.15).
REQ-008 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-low reset (one clock domain, reset sampled only on rising clk, asserted when 0).
REQ-009 SHALL have ports: x_in  in  WIDTH signed  input sample; x_valid  in  1  sample strobe.
REQ-010 SHALL have ports: alpha  out  WIDTH signed  smoothing coefficient for downstream filter; alpha_valid  out  1  alpha update strobe.
REQ-011 SHALL have ports: speech_active  out  1  high in SPEECH/HANGOVER; noise_floor  out  WIDTH unsigned  current floor estimate.

Function
REQ-012 SHALL compute mag = |x_in|, saturating -32768 to 32767.
REQ-013 SHALL update env on each x_valid: if mag>env, env += max((mag-env)>>ATTACK_SHIFT, 1); if mag<env, env -= max((env-mag)>>RELEASE_SHIFT, 1); else hold; env_next denotes the updated value.
REQ-014 SHALL track window_min = min(window_min, env_next) per valid sample; win_cnt counts 0..WIN_LEN-1 and wraps.
REQ-015 SHALL, on the valid sample with win_cnt==WIN_LEN-1, load noise_floor <= min(window_min, env_next) and window_min <= 32767.
REQ-016 SHALL compute thr = noise_floor << THR_SHIFT in WIDTH+THR_SHIFT unsigned bits without overflow; "loud" = env_next > thr (strict), using the registered noise_floor before any same-cycle update.
REQ-017 SHALL implement FSM WARMUP, NOISE, SPEECH, HANGOVER, advancing only on x_valid.
REQ-018 WARMUP SHALL go to NOISE at the first window end (REQ-015); loud is ignored in WARMUP.
REQ-019 NOISE SHALL go to SPEECH when loud.
REQ-020 SHALL go SPEECH -> HANGOVER when not loud, loading hang_cnt = HANG_LEN-1.
REQ-021 HANGOVER SHALL: if loud -> SPEECH; else if hang_cnt==0 -> NOISE; else hang_cnt decrements.
REQ-022 Target alpha SHALL be ALPHA_MIN in NOISE, ALPHA_MAX in WARMUP/SPEECH/HANGOVER, taken from the next state.
REQ-023 alpha_valid SHALL pulse exactly one cycle after each x_valid cycle (latency 1); alpha, speech_active, noise_floor update on the same edge.
REQ-024 SHALL hold all state, alpha and counters while x_valid=0; alpha_valid=0.
REQ-025 Back-to-back x_valid every cycle SHALL be supported with no stalls.

Reset
REQ-026 With reset=0 at a rising clk, SHALL set alpha=ALPHA_MAX, alpha_valid=0, speech_active=0, noise_floor=0, env=0, window_min=32767, win_cnt=0, hang_cnt=0, state=WARMUP.
REQ-027 Reset SHALL override x_valid in the same cycle; mid-operation reset discards all history.

Configuration
REQ-028 Macro ALPHA_RAMP_EN defined: alpha SHALL slew toward target by at most ALPHA_STEP per valid sample, clamped exactly at target.
REQ-029 ALPHA_RAMP_EN undefined: alpha SHALL equal target on the update following each valid sample; no ramp logic.

Verification
REQ-030 Reset: hold reset=0 for 3 cycles with x_valid=1 -> alpha=32767, alpha_valid=0, speech_active=0, noise_floor=0.
REQ-031 x_in=0 for 1024 valid samples -> state NOISE after sample 1024, noise_floor=0; with ALPHA_RAMP_EN alpha reaches 1638 exactly 487 samples later (without: immediately).
REQ-032 From NOISE (floor 0), single x_in=8000 -> env=2000, speech_active=1 one cycle later, alpha rises by 64 per sample (ramp on).
REQ-033 Then x_in=0 continuous -> env decays to 0, state HANGOVER on that sample, speech_active falls 256 samples later, alpha ramps back to 1638.
REQ-034 x_in=-32768 from reset -> mag=32767, env_next=8191; x_valid low 10 cycles mid-ramp -> alpha unchanged, alpha_valid=0 throughout.
REQ-035 Assert reset=0 during HANGOVER -> next cycle all outputs at reset values, WARMUP restarts window count from 0.
